prog_loader: RTL and testbench

Program loader for the 32-word VeriRISC CPU memory. It accepts a byte stream over a valid/ready handshake and writes it into memory from address 0 upward. When `FILL_HLT` is set, it pads the rest of memory with HLT (0x00). It then reads the loaded words back and checks an 8-bit checksum, and only on a match releases the CPU from reset. It drives the memory write side while the CPU is held, and sits between the testbench or host stream and the memory port.

---
 rtl/prog_loader.sv | 116 +++++++++++
 tb/tb_prog_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: streams a program into CPU memory, HLT-fills the rest, verifies it by checksum, then releases the CPU
module prog_loader #(
  parameter int DEPTH = 32,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter bit FILL_HLT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [7:0]        mem_wr_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [7:0]        mem_rd_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [AWIDTH:0]   word_count
);
  typedef enum logic [2:0] {IDLE, LOAD, FILL, VERIFY, CHECK, DONE, ERROR} state_t;
  localparam logic [AWIDTH:0] LAST_ADDR = (AWIDTH+1)'(DEPTH - 1);
  state_t state_q;
  logic in_ready_q, mem_write_q, mem_read_q, rd_valid_q, cpu_run_q, done_q, error_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [7:0] mem_wr_data_q, wsum_q, rsum_q;
  logic [AWIDTH:0] wc_q, ptr_q;
  logic hs, load_end, go_fill;
  assign hs = in_valid && in_ready_q;
  assign load_end = in_last || wc_q == LAST_ADDR;
  assign go_fill = FILL_HLT && wc_q != LAST_ADDR;
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      in_ready_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q <= 1'b0;
      rd_valid_q <= 1'b0;
      cpu_run_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wr_data_q <= '0;
      wsum_q <= '0;
      rsum_q <= '0;
      wc_q <= '0;
      ptr_q <= '0;
    end else begin
      rd_valid_q <= mem_read_q;
      case (state_q)
        IDLE, DONE, ERROR: if (start) begin
          state_q <= LOAD;
          in_ready_q <= 1'b1;
          wc_q <= '0;
          wsum_q <= '0;
          rsum_q <= '0;
          done_q <= 1'b0;
          error_q <= 1'b0;
          cpu_run_q <= 1'b0;
        end
        LOAD: begin
          mem_write_q <= hs;
          if (hs) begin
            mem_addr_q <= wc_q[AWIDTH-1:0];
            mem_wr_data_q <= in_data;
            wsum_q <= wsum_q + in_data;
            wc_q <= wc_q + 1'b1;
            if (load_end) begin
              in_ready_q <= 1'b0;
              state_q <= go_fill ? FILL : VERIFY;
              ptr_q <= go_fill ? wc_q + 1'b1 : '0;
            end
          end
        end
        FILL: begin
          mem_write_q <= 1'b1;
          mem_addr_q <= ptr_q[AWIDTH-1:0];
          mem_wr_data_q <= 8'h00;
          ptr_q <= ptr_q == LAST_ADDR ? '0 : ptr_q + 1'b1;
          if (ptr_q == LAST_ADDR) state_q <= VERIFY;
        end
        VERIFY: begin
          mem_write_q <= 1'b0;
          mem_read_q <= ptr_q != wc_q;
          if (ptr_q != wc_q) begin
            mem_addr_q <= ptr_q[AWIDTH-1:0];
            ptr_q <= ptr_q + 1'b1;
          end
          if (rd_valid_q) rsum_q <= rsum_q + mem_rd_data;
          if (rd_valid_q && !mem_read_q) state_q <= CHECK;
        end
        CHECK: begin
          state_q <= wsum_q == rsum_q ? DONE : ERROR;
          done_q <= wsum_q == rsum_q;
          cpu_run_q <= wsum_q == rsum_q;
          error_q <= wsum_q != rsum_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = in_ready_q;
  assign mem_addr = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_write = mem_write_q;
  assign mem_read = mem_read_q;
  assign cpu_run = cpu_run_q;
  assign done = done_q;
  assign error = error_q;
  assign word_count = wc_q;
  assign busy = !(state_q inside {IDLE, DONE, ERROR});
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader with a registered-read memory model
module tb_prog_loader;
  localparam int DEPTH = 32;
  logic clk = 1'b0, rst_ = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_data = 8'h00, mem_rd_data = 8'h00;
  logic in_ready, mem_write, mem_read, cpu_run, busy, done, error;
  logic [4:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic [5:0] word_count;
  logic [7:0] mem [DEPTH];
  logic [7:0] exp_img [DEPTH];
  logic [7:0] snap [DEPTH];
  logic [12:0] exp_q [$];
  logic [12:0] obs_q [$];
  logic [7:0] prog [$];
  int errors = 0, checks = 0, overlap = 0, cyc = 0, t0 = 0, exp_wc = 0, sb_idx = 0;
  bit corrupt = 1'b0, scrub = 1'b0;

  prog_loader dut (
    .clk(clk), .rst_(rst_), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rd_data(mem_rd_data), .cpu_run(cpu_run),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (scrub) for (int a = 0; a < DEPTH; a++) mem[a] <= 8'h5A;
    else if (mem_write) mem[mem_addr] <= mem_wr_data;
    if (mem_read) mem_rd_data <= mem[mem_addr] ^ {7'd0, corrupt && mem_addr == 5'd2};
  end

  always @(negedge clk) begin
    if (mem_write && mem_read) overlap <= overlap + 1;
    if (mem_write === 1'b1) obs_q.push_back({mem_addr, mem_wr_data});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    t0 = cyc;
    exp_wc = 0;
  endtask

  task automatic send(input logic [7:0] d, input bit last, input bit gaps);
    bit ok = 1'b0;
    int g = 0;
    while (!ok && g < 100) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = d;
      in_last = last;
      if (in_valid && in_ready) begin
        ok = 1'b1;
        exp_q.push_back({exp_wc[4:0], d});
        exp_img[exp_wc] = d;
        exp_wc++;
      end
      tick;
      g++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic push_fill;
    for (int a = exp_wc; a < DEPTH; a++) begin
      exp_q.push_back({a[4:0], 8'h00});
      exp_img[a] = 8'h00;
    end
  endtask

  task automatic wait_end(input string name, output int lat);
    int g = 0;
    while (!done && !error && g < 400) begin
      tick;
      g++;
    end
    checks++;
    if (g >= 400) begin
      errors++;
      $display("FAIL %s timeout: done=%b error=%b after %0d cycles, required done or error", name, done, error, g);
    end
    lat = cyc - t0;
  endtask

  task automatic score_writes(input string name);
    logic [12:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (sb_idx >= obs_q.size()) begin
        errors++;
        $display("FAIL %s write missing: got none, required addr=%0d data=%h", name, e[12:8], e[7:0]);
      end else begin
        if (obs_q[sb_idx] !== e) begin
          errors++;
          $display("FAIL %s write: got addr=%0d data=%h, required addr=%0d data=%h", name, obs_q[sb_idx][12:8], obs_q[sb_idx][7:0], e[12:8], e[7:0]);
        end
        sb_idx++;
      end
    end
    checks++;
    if (sb_idx != obs_q.size()) begin
      errors++;
      $display("FAIL %s extra writes: got %0d unexpected, required 0", name, obs_q.size() - sb_idx);
      sb_idx = obs_q.size();
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0, first = -1;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== exp_img[a]) begin
      bad++;
      if (first < 0) first = a;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s memory: %0d words wrong, first addr=%0d got %h required %h", name, bad, first, mem[first], exp_img[first]);
    end
  endtask

  task automatic test_reset;
    rst_ = 1'b1;
    start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    checks++;
    if ({in_ready, mem_write, mem_read, cpu_run, busy, done, error} !== 7'b0) begin
      errors++;
      $display("FAIL reset strobes: got %b required 0000000", {in_ready, mem_write, mem_read, cpu_run, busy, done, error});
    end
    checks++;
    if (mem_addr !== 5'd0 || mem_wr_data !== 8'h00 || word_count !== 6'd0) begin
      errors++;
      $display("FAIL reset values: got addr=%0d data=%h wc=%0d required 0 0 0", mem_addr, mem_wr_data, word_count);
    end
    rst_ = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset idle: got busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    prog = '{8'hA0, 8'h41, 8'h05, 8'h00};
    do_start;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic load entry: got in_ready=%b busy=%b required 1 1", in_ready, busy);
    end
    foreach (prog[i]) send(prog[i], i == 3, 1'b0);
    push_fill;
    wait_end("basic", lat);
    checks++;
    if (lat != 39) begin
      errors++;
      $display("FAIL basic latency: got %0d required 39", lat);
    end
    checks++;
    if ({done, cpu_run, error, busy} !== 4'b1100) begin
      errors++;
      $display("FAIL basic status: got done/run/err/busy=%b required 1100", {done, cpu_run, error, busy});
    end
    checks++;
    if (word_count !== 6'd4) begin
      errors++;
      $display("FAIL basic word_count: got %0d required 4", word_count);
    end
    score_writes("basic");
    check_mem("basic");
  endtask

  task automatic test_overflow;
    int lat, bad = 0;
    do_start;
    for (int i = 0; i < 32; i++) send(8'(i * 7 + 3), 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (in_ready !== 1'b0) bad++;
      tick;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL overflow in_ready: high in %0d cycles after addr 31, required 0", bad);
    end
    wait_end("overflow", lat);
    checks++;
    if (lat != 67) begin
      errors++;
      $display("FAIL overflow latency: got %0d required 67", lat);
    end
    checks++;
    if (word_count !== 6'd32 || done !== 1'b1) begin
      errors++;
      $display("FAIL overflow status: got wc=%0d done=%b required 32 1", word_count, done);
    end
    score_writes("overflow");
    check_mem("overflow");
  endtask

  task automatic test_gaps;
    int lat, base;
    prog.delete();
    for (int i = 0; i < 10; i++) prog.push_back(8'($urandom));
    do_start;
    foreach (prog[i]) send(prog[i], i == 9, 1'b0);
    push_fill;
    wait_end("nogap", lat);
    checks++;
    if (lat != 45 || done !== 1'b1) begin
      errors++;
      $display("FAIL nogap run: got latency=%0d done=%b required 45 1", lat, done);
    end
    score_writes("nogap");
    for (int a = 0; a < DEPTH; a++) snap[a] = mem[a];
    scrub = 1'b1;
    tick;
    scrub = 1'b0;
    base = obs_q.size();
    do_start;
    foreach (prog[i]) send(prog[i], i == 9, 1'b1);
    push_fill;
    wait_end("gaps", lat);
    checks++;
    if (obs_q.size() - base != 32) begin
      errors++;
      $display("FAIL gaps write count: got %0d required 32", obs_q.size() - base);
    end
    checks++;
    if (done !== 1'b1 || word_count !== 6'd10) begin
      errors++;
      $display("FAIL gaps status: got done=%b wc=%0d required 1 10", done, word_count);
    end
    score_writes("gaps");
    for (int a = 0; a < DEPTH; a++) exp_img[a] = snap[a];
    check_mem("gaps_vs_nogap");
  endtask

  task automatic test_corrupt;
    int lat;
    prog = '{8'hA0, 8'h41, 8'h05, 8'h00};
    corrupt = 1'b1;
    do_start;
    foreach (prog[i]) send(prog[i], i == 3, 1'b0);
    push_fill;
    wait_end("corrupt", lat);
    checks++;
    if ({error, done, cpu_run, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL corrupt status: got err/done/run/busy=%b required 1000", {error, done, cpu_run, busy});
    end
    score_writes("corrupt");
    corrupt = 1'b0;
    do_start;
    checks++;
    if (error !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart clear: got err=%b done=%b busy=%b required 0 0 1", error, done, busy);
    end
    foreach (prog[i]) send(prog[i], i == 3, 1'b0);
    push_fill;
    wait_end("rerun", lat);
    checks++;
    if ({done, cpu_run, error} !== 3'b110 || lat != 39) begin
      errors++;
      $display("FAIL rerun: got done/run/err=%b latency=%0d required 110 39", {done, cpu_run, error}, lat);
    end
    score_writes("rerun");
  endtask

  task automatic test_start_ignored;
    int lat;
    do_start;
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (word_count !== 6'd2 || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start ignored: got wc=%0d in_ready=%b busy=%b required 2 1 1", word_count, in_ready, busy);
    end
    send(8'h33, 1'b0, 1'b0);
    send(8'h44, 1'b1, 1'b0);
    push_fill;
    wait_end("start_ignored", lat);
    checks++;
    if (done !== 1'b1 || word_count !== 6'd4 || lat != 40) begin
      errors++;
      $display("FAIL start ignored end: got done=%b wc=%0d latency=%0d required 1 4 40", done, word_count, lat);
    end
    score_writes("start_ignored");
  endtask

  task automatic test_reset_mid_load;
    do_start;
    send(8'hA0, 1'b0, 1'b0);
    send(8'h41, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data = 8'h05;
    rst_ = 1'b1;
    tick;
    checks++;
    if ({in_ready, mem_write, mem_read, cpu_run, busy, done, error} !== 7'b0 || word_count !== 6'd0 || mem_addr !== 5'd0) begin
      errors++;
      $display("FAIL mid-load reset: got strobes=%b wc=%0d addr=%0d required 0 0 0", {in_ready, mem_write, mem_read, cpu_run, busy, done, error}, word_count, mem_addr);
    end
    rst_ = 1'b0;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL post-reset idle: got busy=%b in_ready=%b run=%b required 0 0 0", busy, in_ready, cpu_run);
    end
    score_writes("reset_mid_load");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_gaps;
    test_corrupt;
    test_start_ignored;
    test_reset_mid_load;
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL read/write overlap: got %0d cycles required 0", overlap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
